// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch (IF)
// and the data stage (DM). Data side has priority, bounded by a starvation
// limit; fetch responses can be killed by a flush; a timeout aborts hung
// transactions and raises a sticky error flag. All outputs are registered.
module mem_port_arbiter #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       STARVE_MAX = 4,
  parameter int unsigned       TIMEOUT    = 64,
  parameter logic [DATA_W-1:0] NOP_INST   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam int unsigned   SW    = $clog2(STARVE_MAX + 2);
  localparam int unsigned   TW    = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              kill_q, kill_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              if_elig, dm_win, done;

  // State and registered outputs; async active-low reset drops any transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      kill_q      <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      kill_q      <= kill_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  // Arbitration, transaction tracking, timeout and response generation.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    kill_d      = kill_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    if_elig     = if_req & ~if_flush;
    dm_win      = dm_req & ~((starve_q == SMAX) & if_elig);
    done        = mem_ack | (tmo_q == TLAST);

    unique case (state_q)
      IDLE: begin
        tmo_d  = '0;
        kill_d = 1'b0;
        if (dm_win) begin
          state_d     = BUSY_D;
          dm_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req)
            starve_d = '0;
          else if (starve_q != SMAX)
            starve_d = starve_q + SW'(1);
        end else if (if_elig) begin
          state_d    = BUSY_I;
          if_gnt_d   = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          starve_d   = '0;
        end else if (!if_req) begin
          starve_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          state_d   = IDLE;
          tmo_d     = '0;
          kill_d    = 1'b0;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!mem_ack)
            err_d = 1'b1;
          if (state_q == BUSY_I) begin
            // A flush in the completing cycle kills the response just like an earlier one.
            if (!(kill_q | if_flush)) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = mem_ack ? mem_rdata : NOP_INST;
            end
          end else begin
            dm_rvalid_d = 1'b1;
            if (!mem_ack)
              dm_rdata_d = '0;
            else if (!mem_we_q)
              dm_rdata_d = mem_rdata;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
          if ((state_q == BUSY_I) && if_flush)
            kill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign dm_rvalid = dm_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random
// transactions, each checked against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned DW         = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TIMEOUT    = 64;
  localparam logic [31:0] NOP        = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_gnt, if_rvalid;
  logic [DW-1:0] if_addr, if_rdata;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ack, err;
  logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          starve_m;
  bit          err_m;
  logic [31:0] exp_if_rdata, exp_dm_rdata;
  logic [1:0]  g_dut;

  mem_port_arbiter #(
    .DATA_W    (DW),
    .STARVE_MAX(STARVE_MAX),
    .TIMEOUT   (TIMEOUT),
    .NOP_INST  (NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    starve_m     = 0;
    err_m        = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  // One arbitration round starting at posedge+1 of an idle cycle.
  // lat: cycle of mem_ack within the busy phase (beyond TIMEOUT = never);
  // flush_at: busy cycle in which if_flush is pulsed (0 = none).
  task automatic txn(input bit ireq, input bit dreq, input bit iflush, input bit we,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                     input int lat, input logic [31:0] rd, input int flush_at);
    int  win;  // 0 none, 1 IF, 2 DM
    bit  ielig, kill, acked;
    int  c;
    if_req = ireq; if_flush = iflush; if_addr = ia;
    dm_req = dreq; dm_we = we; dm_addr = da; dm_wdata = wd; mem_ack = 1'b0;
    ielig = ireq && !iflush;
    if (dreq && !(starve_m == STARVE_MAX && ielig)) win = 2;
    else if (ielig) win = 1;
    else win = 0;
    if (win == 1 || !ireq) starve_m = 0;
    else if (win == 2 && starve_m < STARVE_MAX) starve_m++;

    @(posedge clk); #1;
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    g_dut = {if_gnt, dm_gnt};
    check("if_gnt", if_gnt, win == 1);
    check("dm_gnt", dm_gnt, win == 2);
    check("mem_req_start", mem_req, win != 0);
    if (win == 0) begin
      check("idle_if_rvalid", if_rvalid, 0);
      check("idle_dm_rvalid", dm_rvalid, 0);
      return;
    end
    check("mem_addr", mem_addr, (win == 1) ? ia : da);
    check("mem_we", mem_we, (win == 2) && we);
    if (win == 2 && we) check("mem_wdata", mem_wdata, wd);

    kill = 1'b0; acked = 1'b0; c = 1;
    forever begin
      if (win == 1 && c == flush_at) begin if_flush = 1'b1; kill = 1'b1; end
      acked = (c == lat);
      mem_ack = acked; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0; if_flush = 1'b0;
      if (acked || c == TIMEOUT) break;
      check("busy_mem_req", mem_req, 1);
      check("busy_gnt", {if_gnt, dm_gnt}, 0);
      check("busy_rvalid", {if_rvalid, dm_rvalid}, 0);
      c++;
    end

    if (!acked) err_m = 1'b1;
    if (win == 1 && !kill) exp_if_rdata = acked ? rd : NOP;
    if (win == 2) begin
      if (!acked) exp_dm_rdata = '0;
      else if (!we) exp_dm_rdata = rd;
    end
    check("if_rvalid", if_rvalid, (win == 1) && !kill);
    check("dm_rvalid", dm_rvalid, win == 2);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("dm_rdata", dm_rdata, exp_dm_rdata);
    check("err", err, err_m);
    check("end_mem_req", mem_req, 0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b0;
    if_req = 0; if_flush = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    model_reset();
    #12;
    check("rst_gnt", {if_gnt, dm_gnt}, 0);
    check("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
    check("rst_mem", {mem_req, mem_we, err}, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // T1: single fetch, ack in the first busy cycle
    txn(1, 0, 0, 0, 32'h100, 0, 0, 1, 32'h00A00093, 0);
    check("t1_if_rdata", if_rdata, 32'h00A00093);

    // T2: simultaneous store and fetch; DM first, then IF
    txn(1, 1, 0, 1, 32'h104, 32'h200, 32'hDEADBEEF, 1, 32'h11112222, 0);
    check("t2_first_dm", g_dut, 2'b01);
    txn(1, 0, 0, 0, 32'h104, 0, 0, 1, 32'h33334444, 0);
    check("t2_then_if", g_dut, 2'b10);

    // T3: both held high -> D,D,D,D,I,D,D,D,D,I
    for (int i = 0; i < 10; i++) begin
      txn(1, 1, 0, 1'($urandom), 32'h180 + i * 4, 32'h280 + i * 4, $urandom, 1, $urandom, 0);
      check("t3_order", g_dut, (i == 4 || i == 9) ? 2'b10 : 2'b01);
    end

    // T4: flushed fetch completes silently
    txn(1, 0, 0, 0, 32'h300, 0, 0, 3, 32'hCAFEF00D, 2);
    check("t4_no_rvalid", if_rvalid, 0);

    // T5: load never acked -> abort with zero data, sticky err, late ack ignored
    txn(0, 1, 0, 0, 0, 32'h400, 0, 1000, 32'h55555555, 0);
    check("t5_dm_rdata", dm_rdata, 0);
    check("t5_err", err, 1);
    mem_ack = 1'b1; mem_rdata = 32'h77777777;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("t5_late_rvalid", {if_rvalid, dm_rvalid}, 0);
    check("t5_late_rdata", dm_rdata, 0);
    check("t5_late_err", err, 1);
    txn(0, 1, 0, 0, 0, 32'h404, 0, 2, 32'h12345678, 0);

    // T6: async reset in the middle of a data transaction
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h500;
    @(posedge clk); #1;
    dm_req = 1'b0;
    check("t6_dm_gnt", dm_gnt, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_mem_req", mem_req, 0);
    check("t6_gnt", {if_gnt, dm_gnt}, 0);
    check("t6_rvalid", {if_rvalid, dm_rvalid}, 0);
    check("t6_err", err, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    txn(1, 0, 0, 0, 32'h600, 0, 0, 1, 32'h0badc0de, 0);

    // Random rounds
    for (int n = 0; n < 300; n++) begin
      int lat, fa;
      bit ir, dr;
      ir  = ($urandom_range(3) != 0);
      dr  = ($urandom_range(3) != 0);
      lat = ($urandom_range(39) == 0) ? 1000 : int'($urandom_range(4, 1));
      fa  = ($urandom_range(5) == 0) ? int'($urandom_range(lat > 4 ? 4 : lat, 1)) : 0;
      r   = $urandom;
      txn(ir, dr, $urandom_range(7) == 0, 1'($urandom), $urandom, $urandom, $urandom,
          lat, r, fa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
